hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline controller for the 5-stage RISC-V core. It sequences the fetch stage through a post-reset boot hold and instruction-memory wait states. It generates the stall/flush enables for the F, D and E pipeline registers, including load-use detection and branch/jump redirect. It also drives the EX-stage operand forwarding selects and owns the redirect (PCSrcE/PCTargetE) path into Fetch_Cycle.

Parameters:
BOOT_CYCLES, 2, cycles fetch is held after reset deasserts (1..15)
XLEN, 32, PC/target width

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous reset, active-high
Rs1D  input  5  rs1 of instruction in D
Rs2D  input  5  rs2 of instruction in D
Rs1E  input  5  rs1 of instruction in E
Rs2E  input  5  rs2 of instruction in E
RdE  input  5  rd of instruction in E
ResultSrcE0  input  1  instruction in E is a load
RdM  input  5  rd in M
RegWriteM  input  1  M writes register file
RdW  input  5  rd in W
RegWriteW  input  1  W writes register file
PCSrcE  input  1  branch taken / jump in E
PCTargetE  input  XLEN  redirect target from E
imem_ready  input  1  instruction memory returns data this cycle
StallF  output  1  hold PC register
StallD  output  1  hold IF/ID register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register (bubble)
ForwardAE  output  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  output  2  SrcB select, same encoding
PCSrcF  output  1  PC mux select into Fetch_Cycle
PCTargetF  output  XLEN  PC redirect target into Fetch_Cycle
fetch_valid  output  1  fetch active (not BOOT, not IMEM_WAIT)

Behaviour:
- Reset (async, rst=1): state=BOOT, boot_cnt=0, redirect_pend=0, target_q=0. While in BOOT: StallF=StallD=FlushD=FlushE=1, PCSrcF=0, PCTargetF=0, fetch_valid=0, ForwardAE/BE=00.
- BOOT: boot_cnt increments each clk after rst falls; at boot_cnt==BOOT_CYCLES-1, next state RUN. First fetch occurs BOOT_CYCLES cycles after reset release. Reset mid-operation returns to BOOT from any state, dropping any pending redirect.
- Forwarding (combinational, all states except BOOT):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00. M has priority over W.
  - ForwardBE is identical using Rs2E.
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- RUN, priority order:
  1. PCSrcE=1: PCSrcF=1, PCTargetF=PCTargetE, FlushD=1, FlushE=1, StallF=StallD=0. lwStall is ignored because the D instruction is wrong-path.
  2. imem_ready=0: next state IMEM_WAIT. In this same cycle, StallF=StallD=1, FlushE=1, fetch_valid=0. This applies only when rule 1 is not active; if PCSrcE=1 and imem_ready=0 together, the redirect is latched as pending and state goes to IMEM_WAIT.
  3. lwStall=1: StallF=StallD=1, FlushE=1, FlushD=0.
  4. Otherwise all stall/flush outputs are 0 and PCSrcF=0.
- IMEM_WAIT: StallF=StallD=1, FlushE=1, PCSrcF=0, fetch_valid=0.
  - PCSrcE=1 in any wait cycle: redirect_pend<=1 and target_q<=PCTargetE; a later PCSrcE overwrites the target.
  - imem_ready=1: next state RUN. In that exit cycle, if redirect_pend=1: PCSrcF=1, PCTargetF=target_q, FlushD=1, FlushE=1, StallF=StallD=0, and redirect_pend<=0.
  - If PCSrcE=1 in the exit cycle, PCTargetE takes precedence over target_q.
- Latency: redirect is combinational (same cycle) in RUN; a redirect deferred by IMEM_WAIT is applied in the exit cycle.
- Register numbers are 5-bit compares. x0 never triggers a hazard or a forward.

Test Plan:
- Reset 3 cycles then release, imem_ready=1 -> StallF=1 and fetch_valid=0 for 2 cycles after release, then StallF=0, fetch_valid=1.
- lw x5 in E (RdE=5, ResultSrcE0=1), Rs1D=5 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle; same case with RdE=0 -> no stall.
- RdM=7 RegWriteM=1, RdW=7 RegWriteW=1, Rs1E=7, Rs2E=7 -> ForwardAE=10, ForwardBE=10; drop RegWriteM -> both 01.
- PCSrcE=1, PCTargetE=0x00000040, concurrent lwStall -> PCSrcF=1, PCTargetF=0x40, FlushD=FlushE=1, StallF=0.
- imem_ready=0 for 3 cycles with PCSrcE=1, PCTargetE=0x80 in the first cycle -> StallF=1 for 3 cycles; on imem_ready=1: PCSrcF=1, PCTargetF=0x80, FlushD=1, then redirect_pend=0.
- Assert rst during IMEM_WAIT with a pending redirect -> immediate BOOT outputs; after release, no stale redirect (PCSrcF=0).

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus between the datapath stages and the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            ResultSrcE0;
  logic [4:0]      RdM;
  logic            RegWriteM;
  logic [4:0]      RdW;
  logic            RegWriteW;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            imem_ready;
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic            PCSrcF;
  logic [XLEN-1:0] PCTargetF;
  logic            fetch_valid;

  // Datapath side: drives register numbers and status, consumes controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, RdM, RegWriteM, RdW, RegWriteW,
           PCSrcE, PCTargetE, imem_ready,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcF, PCTargetF,
           fetch_valid
  );

  // Controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, RdM, RegWriteM, RdW, RegWriteW,
           PCSrcE, PCTargetE, imem_ready,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcF, PCTargetF,
           fetch_valid
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: boot hold, imem wait sequencing, load-use stall,
// branch redirect (with deferral across imem waits) and EX forwarding.
module hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StBoot, StRun, StImemWait} state_e;

  state_e          r_state, w_state_next;
  logic [3:0]      r_boot_cnt, w_boot_cnt_next;
  logic            r_redirect_pend, w_redirect_pend_next;
  logic [XLEN-1:0] r_target, w_target_next;

  logic [1:0]      w_fwd_a, w_fwd_b;
  logic            w_lw_stall;

  // Operand forwarding: M stage result has priority over W; x0 never forwards.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs1E)      w_fwd_a = 2'b10;
    else if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs1E) w_fwd_a = 2'b01;
    if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs2E)      w_fwd_b = 2'b10;
    else if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs2E) w_fwd_b = 2'b01;
  end

  assign w_lw_stall = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // State, boot counter and deferred-redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= StBoot;
      r_boot_cnt      <= 4'd0;
      r_redirect_pend <= 1'b0;
      r_target        <= '0;
    end else begin
      r_state         <= w_state_next;
      r_boot_cnt      <= w_boot_cnt_next;
      r_redirect_pend <= w_redirect_pend_next;
      r_target        <= w_target_next;
    end
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    w_state_next         = r_state;
    w_boot_cnt_next      = r_boot_cnt;
    w_redirect_pend_next = r_redirect_pend;
    w_target_next        = r_target;
    bus.StallF           = 1'b0;
    bus.StallD           = 1'b0;
    bus.FlushD           = 1'b0;
    bus.FlushE           = 1'b0;
    bus.ForwardAE        = w_fwd_a;
    bus.ForwardBE        = w_fwd_b;
    bus.PCSrcF           = 1'b0;
    bus.PCTargetF        = '0;
    bus.fetch_valid      = 1'b0;

    case (r_state)
      StBoot: begin
        bus.StallF    = 1'b1;
        bus.StallD    = 1'b1;
        bus.FlushD    = 1'b1;
        bus.FlushE    = 1'b1;
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b00;
        if (r_boot_cnt == 4'(BOOT_CYCLES - 1)) w_state_next = StRun;
        else                                   w_boot_cnt_next = r_boot_cnt + 4'd1;
      end
      StRun: begin
        bus.fetch_valid = 1'b1;
        if (!bus.imem_ready) begin
          // A redirect coinciding with an imem miss is deferred to the wait exit.
          w_state_next    = StImemWait;
          bus.StallF      = 1'b1;
          bus.StallD      = 1'b1;
          bus.FlushE      = 1'b1;
          bus.fetch_valid = 1'b0;
          if (bus.PCSrcE) begin
            w_redirect_pend_next = 1'b1;
            w_target_next        = bus.PCTargetE;
          end
        end else if (bus.PCSrcE) begin
          // D holds a wrong-path instruction, so any load-use stall is moot.
          bus.PCSrcF    = 1'b1;
          bus.PCTargetF = bus.PCTargetE;
          bus.FlushD    = 1'b1;
          bus.FlushE    = 1'b1;
        end else if (w_lw_stall) begin
          bus.StallF = 1'b1;
          bus.StallD = 1'b1;
          bus.FlushE = 1'b1;
        end
      end
      StImemWait: begin
        bus.StallF = 1'b1;
        bus.StallD = 1'b1;
        bus.FlushE = 1'b1;
        if (bus.imem_ready) begin
          w_state_next         = StRun;
          w_redirect_pend_next = 1'b0;
          if (bus.PCSrcE || r_redirect_pend) begin
            bus.PCSrcF    = 1'b1;
            bus.PCTargetF = bus.PCSrcE ? bus.PCTargetE : r_target;
            bus.FlushD    = 1'b1;
            bus.StallF    = 1'b0;
            bus.StallD    = 1'b0;
          end
        end else if (bus.PCSrcE) begin
          w_redirect_pend_next = 1'b1;
          w_target_next        = bus.PCTargetE;
        end
      end
      default: w_state_next = StBoot;
    endcase
  end

endmodule
